// File: rtl/rv_defs.sv
// Shared RISC-V fetch-side definitions: word width, the NOP used on faults,
// error codes and the packed response record carried through the response FIFO.
package rv_defs;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10
  } err_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    err_e            err;
  } resp_t;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response buffer with 1-bit wrapping pointers and an occupancy count.
// The head reads as zero while empty so idle response outputs are clean.
module resp_fifo2 #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  // Reset and flush both discard everything; otherwise push and pop are independent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push_i) r_wr_ptr <= ~r_wr_ptr;
      if (pop_i)  r_rd_ptr <= ~r_rd_ptr;
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !flush_i && push_i) r_mem[r_wr_ptr] <= din_i;
  end

  assign dout_o  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
  assign count_o = r_count;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: accepts byte-address fetches, reads the array
// combinationally, classifies address faults and queues responses in order.
module inst_rom_resp
  import rv_defs::*;
#(
  parameter int              DEPTH_WORDS = 4096,
  parameter int              AW          = 12,
  parameter logic [XLEN-1:0] NOP_INST_P  = NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_inst_o,
  output logic [XLEN-1:0] resp_addr_o,
  output logic [1:0]      resp_err_o,
  input  logic            prog_we_i,
  input  logic [AW-1:0]   prog_addr_i,
  input  logic [XLEN-1:0] prog_data_i
);

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  logic [XLEN-1:0] w_rd_word;
  err_e            w_err;
  resp_t           w_push_data;
  resp_t           w_head;
  logic [1:0]      w_count;
  logic            w_push;
  logic            w_pop;

  // Program-load port; deliberately independent of reset and flush.
  always_ff @(posedge clk) begin
    if (prog_we_i) r_mem[prog_addr_i] <= prog_data_i;
  end

  assign w_rd_word = r_mem[req_addr_i[AW+1:2]];

  // Misalignment wins over range so a bad low address is always reported as such.
  always_comb begin
    w_err = ERR_OK;
    if (req_addr_i[1:0] != 2'b00)       w_err = ERR_MISALIGN;
    else if (|req_addr_i[XLEN-1:AW+2])  w_err = ERR_RANGE;
  end

  always_comb begin
    w_push_data      = '0;
    w_push_data.inst = (w_err == ERR_OK) ? w_rd_word : NOP_INST_P;
    w_push_data.addr = req_addr_i;
    w_push_data.err  = w_err;
  end

  assign resp_valid_o = (w_count != 2'd0);
  assign w_pop        = resp_valid_o && resp_ready_i;
  assign req_ready_o  = !flush_i && ((w_count < 2'd2) || w_pop);
  assign w_push       = req_valid_i && req_ready_o;

  resp_fifo2 #(
    .W($bits(resp_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .din_i   (w_push_data),
    .dout_o  (w_head),
    .count_o (w_count)
  );

  assign resp_inst_o = w_head.inst;
  assign resp_addr_o = w_head.addr;
  assign resp_err_o  = w_head.err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed test of inst_rom_resp: streaming, backpressure, faults, flush,
// write/fetch collision and mid-operation reset.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic [31:0] resp_addr;
  logic [1:0]  resp_err;
  logic        prog_we;
  logic [11:0] prog_addr;
  logic [31:0] prog_data;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  inst_rom_resp dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_inst_o  (resp_inst),
    .resp_addr_o  (resp_addr),
    .resp_err_o   (resp_err),
    .prog_we_i    (prog_we),
    .prog_addr_i  (prog_addr),
    .prog_data_i  (prog_data)
  );

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== 67'd0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h want %h", {resp_valid, resp_inst, resp_addr, resp_err}, 67'd0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic load_program();
    logic [31:0] words [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 12'(i);
      prog_data = words[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
    $display("[TB] test_back_to_back");
    resp_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        checks++;
        if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, exp[i-1], 32'(4*(i-1)), 2'b00}) begin
          fails++;
          $display("[TB] FAIL b2b_resp%0d: got %h want %h", i-1,
                   {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, exp[i-1], 32'(4*(i-1)), 2'b00});
        end
      end
      if (i < 4) begin
        req_valid = 1'b1;
        req_addr  = 32'(4*i);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
          fails++;
          $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, req_ready);
        end
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_drained: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    @(negedge clk);
    req_addr = 32'h4;
    @(negedge clk);
    req_addr = 32'h8;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_full_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, 32'h00100093, 32'h0, 2'b00}) begin
      fails++;
      $display("[TB] FAIL bp_head_hold: got %h want %h",
               {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, 32'h00100093, 32'h0, 2'b00});
    end
    // Releasing the consumer frees a slot in the same cycle as the waiting request.
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL bp_pop_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, 32'h00200113, 32'h4, 2'b00}) begin
      fails++;
      $display("[TB] FAIL bp_drain1: got %h want %h",
               {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, 32'h00200113, 32'h4, 2'b00});
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, 32'h00300193, 32'h8, 2'b00}) begin
      fails++;
      $display("[TB] FAIL bp_drain2: got %h want %h",
               {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, 32'h00300193, 32'h8, 2'b00});
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_empty: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h6, 32'h4000, 32'h4002};
    logic [1:0]  errs  [3] = '{2'b01, 2'b10, 2'b01};
    $display("[TB] test_errors");
    resp_ready = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        checks++;
        if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, 32'h00000013, addrs[i-1], errs[i-1]}) begin
          fails++;
          $display("[TB] FAIL err_resp%0d: got %h want %h", i-1,
                   {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, 32'h00000013, addrs[i-1], errs[i-1]});
        end
      end
      req_valid = (i < 3);
      if (i < 3) req_addr = addrs[i];
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    $display("[TB] test_flush");
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    @(negedge clk);
    req_addr = 32'h4;
    @(negedge clk);
    flush    = 1'b1;
    req_addr = 32'hC;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_addr   = 32'h8;
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_valid: got %b want 0", resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== {1'b1, 32'h00300193, 32'h8, 2'b00}) begin
      fails++;
      $display("[TB] FAIL flush_refetch: got %h want %h",
               {resp_valid, resp_inst, resp_addr, resp_err}, {1'b1, 32'h00300193, 32'h8, 2'b00});
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flush_no_stale: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_write_collision();
    $display("[TB] test_write_collision");
    resp_ready = 1'b1;
    prog_we    = 1'b1;
    prog_addr  = 12'd1;
    prog_data  = 32'hDEADBEEF;
    req_valid  = 1'b1;
    req_addr   = 32'h4;
    @(negedge clk);
    prog_we = 1'b0;
    checks++;
    if (resp_inst !== 32'h00200113) begin
      fails++;
      $display("[TB] FAIL wr_old_data: got %h want %h", resp_inst, 32'h00200113);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (resp_inst !== 32'hDEADBEEF) begin
      fails++;
      $display("[TB] FAIL wr_new_data: got %h want %h", resp_inst, 32'hDEADBEEF);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    $display("[TB] test_reset_midop");
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h0;
    @(negedge clk);
    req_addr = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({resp_valid, resp_inst, resp_addr, resp_err} !== 67'd0) begin
      fails++;
      $display("[TB] FAIL rst_mid_outputs: got %h want %h", {resp_valid, resp_inst, resp_addr, resp_err}, 67'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h4;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rst_mid_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    req_addr = 32'h0;
    checks++;
    if ({resp_valid, resp_inst, resp_addr} !== {1'b1, 32'hDEADBEEF, 32'h4}) begin
      fails++;
      $display("[TB] FAIL rst_mem_word1: got %h want %h", {resp_valid, resp_inst, resp_addr}, {1'b1, 32'hDEADBEEF, 32'h4});
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_inst, resp_addr} !== {1'b1, 32'h00100093, 32'h0}) begin
      fails++;
      $display("[TB] FAIL rst_mem_word0: got %h want %h", {resp_valid, resp_inst, resp_addr}, {1'b1, 32'h00100093, 32'h0});
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = 12'd0;
    prog_data  = 32'h0;
    test_reset();
    load_program();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_flush();
    test_write_collision();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
Instruction-memory responder: the fetch-side slave that the program counter drives.
- Accepts fetch requests (byte address) over a valid/ready handshake and returns the addressed 32-bit instruction one cycle later over a second valid/ready handshake.
- Buffers up to 2 responses, flags bad addresses, supports flush on redirect, and has a write port for loading programs.
- Sits between the PC/fetch stage and the IF/ID register.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit instruction words stored (power of two)
AW, 12, word-index width, equal to log2(DEPTH_WORDS)
NOP_INST, 32'h00000013, instruction returned on error (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
req_valid_i  input  1  fetch request valid
req_ready_o  output  1  responder can accept a request this cycle
req_addr_i  input  32  fetch byte address
flush_i  input  1  discard all buffered responses and any same-cycle request
resp_valid_o  output  1  response valid
resp_ready_i  input  1  consumer accepts the response
resp_inst_o  output  32  instruction word
resp_addr_o  output  32  byte address the response belongs to
resp_err_o  output  2  00 ok, 01 misaligned, 10 out of range
prog_we_i  input  1  program-load write enable
prog_addr_i  input  AW  program-load word index
prog_data_i  input  32  program-load data

Behaviour:
Reset (rst==0 at a rising edge):
- FIFO emptied.
- resp_valid_o=0; resp_inst_o, resp_addr_o and resp_err_o = 0.
- Memory contents are not reset.
- Reset mid-operation drops all buffered responses; no response appears for a request accepted before reset.

Request acceptance and latency:
- A request is accepted at an edge where req_valid_i && req_ready_o.
- The array is read combinationally at acceptance. Word, address and error are pushed into a 2-entry response FIFO at that edge.
- Fixed latency: a request accepted at edge N makes resp_valid_o go high after edge N if the FIFO was empty.
- Otherwise the response appears in order behind the older entries.

req_ready_o rule:
- req_ready_o = !flush_i && (count<2 || (resp_valid_o && resp_ready_i)).
- Simultaneous push and pop while full is allowed; count stays 2.
- Back-to-back requests at 1 per cycle are sustained when resp_ready_i is held high.

Response side:
- A response pops at an edge where resp_valid_o && resp_ready_i.
- resp_valid_o = (count!=0). Outputs always show the FIFO head.
- While resp_valid_o && !resp_ready_i, all resp_* outputs hold stable.

Error classification (evaluated at acceptance):
- req_addr_i[1:0]!=0 gives err=01. This takes priority.
- Else req_addr_i[31:2] >= DEPTH_WORDS gives err=10.
- On any error, resp_inst_o=NOP_INST and resp_addr_o is still the request address.
- Errors do not stall; they are ordinary responses.

Flush:
- flush_i=1 at an edge sets count to 0; resp_valid_o=0 in the next cycle.
- A pop and any push at that edge are both void. req_ready_o is 0 during flush, so no request can be accepted.
- The edge after flush deasserts, a new request can be accepted.

Program load:
- prog_we_i writes prog_data_i to word prog_addr_i at the edge.
- A fetch accepted at the same edge to the same word captures the OLD contents; the new contents are visible from the next edge.
- Writes are permitted during reset and during flush.

FIFO pointers:
- 1-bit read/write pointers with wrap-around, plus a 2-bit count (0..2).

Decomposition:
- Shared package rv_defs: NOP_INST, error codes (ERR_OK=2'b00, ERR_MISALIGN=2'b01, ERR_RANGE=2'b10), XLEN=32.
- One sub-module, resp_fifo2: a 2-entry, 66-bit wide FIFO (inst + addr + err) with push, pop, flush and count outputs.
- Array, address check and handshake logic stay at the top level.

Test Plan:
- Program words 0..3 with 0x00100093, 0x00200113, 0x00300193, 0x00400213. Fetch addresses 0,4,8,12 back-to-back with resp_ready_i=1 -> resp_valid_o high on 4 consecutive cycles starting 1 cycle after the first accept, with the 4 words in order, err=00, req_ready_o constantly 1.
- Hold resp_ready_i=0 and issue 3 requests -> only 2 accepted, req_ready_o=0 on the third cycle, head stays addr 0 / 0x00100093 unchanged. Release ready -> remaining responses drain in order, then the third request is accepted.
- Fetch address 0x6 -> err=01, inst=0x00000013, addr=0x6. Fetch 0x4000 (word 4096) -> err=10, inst=0x00000013. Fetch 0x4002 -> err=01 (misalignment has priority).
- With 2 responses buffered, assert flush_i together with req_valid_i for one cycle -> req_ready_o=0 that cycle, resp_valid_o=0 the next cycle, no stale response ever emitted. A fetch of 0x8 the following cycle returns 0x00300193.
- At one edge, prog-write word 1=0xDEADBEEF and accept a fetch of 0x4 -> response is 0x00200113. A fetch of 0x4 on the next cycle -> 0xDEADBEEF.
- Drive rst=0 for one edge while 2 responses are buffered -> resp_valid_o=0 and resp_* = 0 afterwards, req_ready_o=1 once rst=1, memory still holds the programmed values.
